// File: rtl/uart_rx_frame.sv
// Multi-byte 8N1 UART receiver with 16x oversampling.
// Assembles NBYTES bytes (first byte in the MSBs) into one word and publishes it
// with a one-cycle done strobe. Stop-bit errors and inter-byte gaps drop the partial word.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_SAMPLE = 651,
  parameter int unsigned NBYTES          = 16,
  parameter int unsigned GAP_BITS        = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         rx,
  output logic [8*NBYTES-1:0]          data_o,
  output logic                         done,
  output logic                         frame_err,
  output logic                         timeout,
  output logic                         busy,
  output logic [$clog2(NBYTES+1)-1:0]  byte_idx
);

  localparam int unsigned DivW     = $clog2(CLKS_PER_SAMPLE);
  localparam int unsigned IdxW     = $clog2(NBYTES + 1);
  localparam int unsigned GapTicks = GAP_BITS * 16;
  localparam int unsigned GapW     = $clog2(GapTicks + 1);
  localparam int unsigned WordW    = 8 * NBYTES;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
  localparam logic [2:0] StWaitHi = 3'd4;  // after a bad stop bit, wait for the line to go high

  logic             rx_meta_q, rx_sync_q;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick;
  logic [2:0]       state_q, state_d;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [WordW-1:0] asm_q, asm_d;
  logic [WordW-1:0] data_q, data_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             to_q, to_d;
  logic             busy_q, busy_d;

  // Sample-tick divider: free-runs, re-zeroed on start-bit detect so ticks align to the edge.
  always_comb begin
    tick  = (div_q == DivW'(CLKS_PER_SAMPLE - 1));
    div_d = tick ? '0 : div_q + 1'b1;
    if (enable && (state_q == StIdle) && !rx_sync_q) div_d = '0;
  end

  // Byte FSM, word assembly and gap timer next-state logic.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    asm_d   = asm_q;
    data_d  = data_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    to_d    = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
      gap_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            // Start detect wins over a timeout in the same cycle.
            state_d = StStart;
            samp_d  = '0;
            busy_d  = 1'b1;
            gap_d   = '0;
          end else if (idx_q == '0) begin
            gap_d = '0;
          end else if (tick) begin
            if (gap_q == GapW'(GapTicks - 1)) begin
              to_d  = 1'b1;
              idx_d = '0;
              gap_d = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        StStart: begin
          if (tick) begin
            if (samp_q == 4'd7) begin
              samp_d = '0;
              if (!rx_sync_q) begin
                state_d = StData;
                bit_d   = '0;
              end else begin
                state_d = StIdle;  // glitch, no error
                busy_d  = 1'b0;
              end
            end else begin
              samp_d = samp_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (samp_q == 4'd15) begin
              samp_d  = '0;
              shift_d = {rx_sync_q, shift_q[7:1]};
              bit_d   = bit_q + 1'b1;
              if (bit_q == 3'd7) state_d = StStop;
            end else begin
              samp_d = samp_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (samp_q == 4'd15) begin
              samp_d = '0;
              busy_d = 1'b0;
              if (rx_sync_q) begin
                state_d = StIdle;
                for (int unsigned i = 0; i < NBYTES; i++) begin
                  if (idx_q == IdxW'(NBYTES - 1 - i)) asm_d[8*i +: 8] = shift_q;
                end
                if (idx_q == IdxW'(NBYTES - 1)) begin
                  data_d = asm_d;
                  done_d = 1'b1;
                  idx_d  = '0;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end else begin
                state_d = StWaitHi;
                ferr_d  = 1'b1;
                idx_d   = '0;
              end
            end else begin
              samp_d = samp_q + 1'b1;
            end
          end
        end
        StWaitHi: begin
          if (rx_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      div_q     <= '0;
      state_q   <= StIdle;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      div_q     <= div_d;
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      asm_q     <= asm_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
    end
  end

  assign data_o    = data_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign timeout   = to_q;
  assign busy      = busy_q;
  assign byte_idx  = idx_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed plus randomized bench for uart_rx_frame with a transaction-level word model.
module tb_uart_rx_frame;

  localparam int unsigned Cps     = 4;
  localparam int unsigned Nb      = 4;
  localparam int unsigned Gap     = 4;
  localparam int          BitClks = Cps * 16;

  logic        clk = 1'b0;
  logic        reset, enable, rx;
  logic [31:0] data_o;
  logic        done, frame_err, timeout, busy;
  logic [2:0]  byte_idx;

  uart_rx_frame #(
    .CLKS_PER_SAMPLE(Cps),
    .NBYTES         (Nb),
    .GAP_BITS       (Gap)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rx       (rx),
    .data_o   (data_o),
    .done     (done),
    .frame_err(frame_err),
    .timeout  (timeout),
    .busy     (busy),
    .byte_idx (byte_idx)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  int          done_cnt = 0, ferr_cnt = 0, to_cnt = 0, both_cnt = 0, chg_bad = 0, busy_rise = 0;
  logic [31:0] prev_data = '0;
  logic        prev_busy = 1'b0;
  logic [2:0]  prev_idx = '0;
  logic [2:0]  idx_log[$];

  always @(negedge clk) begin
    if (reset) begin
      prev_data = data_o;
      prev_busy = busy;
      prev_idx  = byte_idx;
    end else begin
      if (done) done_cnt++;
      if (frame_err) ferr_cnt++;
      if (timeout) to_cnt++;
      if (done && frame_err) both_cnt++;
      if (data_o !== prev_data && !done) chg_bad++;
      if (busy && !prev_busy) busy_rise++;
      if (byte_idx !== prev_idx) idx_log.push_back(byte_idx);
      prev_data = data_o;
      prev_busy = busy;
      prev_idx  = byte_idx;
    end
  end

  // Reference model: a word is the concatenation of the last Nb good bytes since
  // the previous word, frame error, long gap, disable or reset.
  logic [7:0]  mdl_q[$];
  logic [31:0] mdl_word = '0;
  int          mdl_done = 0, mdl_ferr = 0, mdl_to = 0;

  task automatic mdl_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      mdl_ferr++;
      mdl_q.delete();
    end else begin
      mdl_q.push_back(b);
      if (mdl_q.size() == Nb) begin
        mdl_word = {mdl_q[0], mdl_q[1], mdl_q[2], mdl_q[3]};
        mdl_done++;
        mdl_q.delete();
      end
    end
  endtask

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the line for n clocks; always returns 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int bits);
    drive(1'b1, bits * BitClks);
    if (bits > Gap && mdl_q.size() > 0) begin
      mdl_to++;
      mdl_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int per);
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(b[i], per);
    drive(ok, per);
    if (!ok) drive(1'b1, per);
    mdl_byte(b, ok);
  endtask

  task automatic send_word(input logic [31:0] w, input int per);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, per);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_done"}, done_cnt, mdl_done);
    check({tag, "_ferr"}, ferr_cnt, mdl_ferr);
    check({tag, "_to"}, to_cnt, mdl_to);
    check({tag, "_data"}, data_o, mdl_word);
  endtask

  int          snap, brise;
  logic [31:0] got;
  logic [7:0]  rb;
  bit          rok;
  int          per;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    rx     = 1'b1;
    #3;
    check("rst_async_data", data_o, 32'h0);
    check("rst_async_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_to", timeout, 0);
    check("rst_idx", byte_idx, 0);
    @(posedge clk);
    #1;
    idle_bits(2);

    // Nominal word and byte_idx progression.
    snap = idx_log.size();
    send_word(32'hDEADBEEF, BitClks);
    idle_bits(2);
    check_counts("s1");
    check("s1_idx_cnt", idx_log.size() - snap, 4);
    for (int k = 0; k < 4; k++) begin
      got = (snap + k < idx_log.size()) ? 32'(idx_log[snap + k]) : 32'hFFFF_FFFF;
      check("s1_idx_seq", got, (k == 3) ? 0 : k + 1);
    end

    // Bad stop bit drops the partial word; old word held until the next done.
    send_byte(8'h12, 1'b1, BitClks);
    send_byte(8'h34, 1'b0, BitClks);
    check("s2_idx_after_ferr", byte_idx, 0);
    send_byte(8'h56, 1'b1, BitClks);
    send_byte(8'h78, 1'b1, BitClks);
    send_byte(8'h9A, 1'b1, BitClks);
    check("s2_held", data_o, 32'hDEADBEEF);
    send_byte(8'hBC, 1'b1, BitClks);
    idle_bits(1);
    check_counts("s2");
    check("s2_word", data_o, 32'h56789ABC);

    // Inter-byte gap timeout, then a clean word.
    send_byte(8'h11, 1'b1, BitClks);
    send_byte(8'h22, 1'b1, BitClks);
    idle_bits(5);
    check("s3_idx", byte_idx, 0);
    send_word(32'hA1A2A3A4, BitClks);
    idle_bits(1);
    check_counts("s3");
    check("s3_word", data_o, 32'hA1A2A3A4);

    // Short glitch on an idle line.
    brise = busy_rise;
    drive(1'b0, 3 * Cps);
    idle_bits(2);
    check("s4_busy_rise", busy_rise - brise, 1);
    check("s4_busy", busy, 0);
    check("s4_idx", byte_idx, 0);
    check_counts("s4");

    // Disable after two bytes, then re-arm.
    send_byte(8'h55, 1'b1, BitClks);
    send_byte(8'h66, 1'b1, BitClks);
    check("s5_idx2", byte_idx, 2);
    enable = 1'b0;
    mdl_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("s5_dis_idx", byte_idx, 0);
    check("s5_dis_data", data_o, 32'hA1A2A3A4);
    enable = 1'b1;
    idle_bits(1);
    send_word(32'h01020304, BitClks);
    idle_bits(1);
    check_counts("s5");
    check("s5_word", data_o, 32'h01020304);

    // Reset in the middle of a data bit.
    drive(1'b0, BitClks);
    drive(1'b1, BitClks / 2);
    check("s5r_busy_pre", busy, 1);
    reset = 1'b1;
    #2;
    check("s5r_data", data_o, 0);
    check("s5r_busy", busy, 0);
    check("s5r_idx", byte_idx, 0);
    check("s5r_done", {done, frame_err, timeout}, 0);
    mdl_q.delete();
    mdl_word = '0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bits(2);
    send_word(32'hCAFEF00D, BitClks);
    idle_bits(1);
    check_counts("s5r");

    // Transmitter about 3% fast, then 3% slow.
    send_word(32'hDEADBEEF, BitClks - 2);
    idle_bits(1);
    check_counts("s6f");
    send_word(32'h0BADF00D, BitClks);
    send_word(32'hDEADBEEF, BitClks + 2);
    idle_bits(1);
    check_counts("s6s");

    // Random bytes, occasional bad stop bit, random rate within tolerance.
    for (int w = 0; w < 6; w++) begin
      for (int b = 0; b < 4; b++) begin
        rb  = 8'($urandom);
        rok = ($urandom_range(0, 7) != 0);
        per = BitClks - 2 + 2 * int'($urandom_range(0, 2));
        send_byte(rb, rok, per);
      end
      check_counts("rnd");
    end
    idle_bits(Gap + 2);
    check_counts("rnd_end");

    check("both_pulses", both_cnt, 0);
    check("data_chg_no_done", chg_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
